// File: rtl/acia_pkg.sv
// -----------------------------------------------------------------------------
// acia_pkg
// Shared definitions for the ACIA receive and transmit halves.
//   rx_state_t      : receiver FSM states (IDLE, START, DATA, STOP)
//   DIVISOR_DEFAULT : clk cycles per 16x sample tick (50 MHz / (19200 * 16))
//   OVERSAMPLE      : sample ticks per bit
//   MID_SAMPLE      : tick index of the start-bit midpoint
// -----------------------------------------------------------------------------
package acia_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DIVISOR_DEFAULT = 163;
  localparam int OVERSAMPLE      = 16;
  localparam int MID_SAMPLE      = 7;

endpackage

// File: rtl/acia_baud_gen.sv
// -----------------------------------------------------------------------------
// acia_baud_gen
// Divisor counter producing the 16x oversampling tick.
//   clk   : system clock
//   RST   : synchronous reset, active-low
//   align : synchronous clear; holds the counter at 0 while asserted so the
//           first tick lands DIVISOR cycles after align drops
//   tick  : one-cycle pulse when the counter wraps from DIVISOR-1 to 0
// -----------------------------------------------------------------------------
module acia_baud_gen
  import acia_pkg::*;
#(
  parameter int DIVISOR = DIVISOR_DEFAULT
) (
  input  logic clk,
  input  logic RST,
  input  logic align,
  output logic tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(DIVISOR - 1));

  always_ff @(posedge clk) begin
    if (!RST || align) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/acia_rx.sv
// -----------------------------------------------------------------------------
// acia_rx
// Receive half of the ACIA: synchronizes rx, samples it at 16x the bit rate,
// deframes 8N1 characters and holds each byte in a one-deep register with
// RDRF / framing / overrun status and a registered interrupt request.
//   clk         : system clock
//   RST         : synchronous reset, active-low
//   rx          : asynchronous serial line, idles high
//   rd_strobe   : one-cycle pulse, CPU reads the receive-data register
//   irq_en      : receive interrupt enable
//   data_out    : holding register
//   rx_full     : a byte is waiting (RDRF)
//   framing_err : stop bit of the held byte was sampled low
//   overrun     : a byte arrived while rx_full was set
//   irq         : rx_full & irq_en, registered
//   dbg_state   : current receiver FSM state
// Build option: define ACIA_RX_MAJORITY_EN for a 2-of-3 vote at each sample
// point; otherwise a single sample is taken. Latency is the same either way.
//
// Holding-register handshake: rx_full acts as "valid" and rd_strobe as the
// consumer's "take". A byte is offered while rx_full=1; a rd_strobe retires
// it on the next edge. A load in the same cycle as rd_strobe replaces the
// retired byte directly, so no frame is lost and overrun is not raised.
// -----------------------------------------------------------------------------
module acia_rx
  import acia_pkg::*;
#(
  parameter int DIVISOR     = DIVISOR_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       rx,
  input  logic       rd_strobe,
  input  logic       irq_en,
  output logic [7:0] data_out,
  output logic       rx_full,
  output logic       framing_err,
  output logic       overrun,
  output logic       irq,
  output rx_state_t  dbg_state
);

  logic [SYNC_STAGES-1:0] r_sync;
  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [3:0]             r_sc;
  logic [2:0]             r_bi;
  logic [7:0]             r_shift;
  logic [7:0]             r_data;
  logic                   r_rx_full;
  logic                   r_framing_err;
  logic                   r_overrun;
  logic                   r_irq;

  logic w_rxs;
  logic w_tick;
  logic w_align;
  logic w_sample;
  logic w_sc_clr;
  logic w_bit_take;
  logic w_load;

  // Synchronizer resets to the idle line level so reset never looks like a
  // start edge.
  always_ff @(posedge clk) begin
    if (!RST) begin
      r_sync <= '1;
    end else begin
      r_sync <= SYNC_STAGES'({r_sync, rx});
    end
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];

  // Counter held in IDLE so tick phase is referenced to the start edge.
  assign w_align = (r_state == IDLE);

  acia_baud_gen #(
    .DIVISOR (DIVISOR)
  ) u_baud (
    .clk   (clk),
    .RST   (RST),
    .align (w_align),
    .tick  (w_tick)
  );

`ifdef ACIA_RX_MAJORITY_EN
  // The two ticks before the decision tick are kept here; the decision tick
  // supplies the third vote, so the decision instant matches the plain build.
  logic [1:0] r_vote;

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_vote <= 2'b11;
    end else if (w_tick) begin
      r_vote <= {r_vote[0], w_rxs};
    end
  end

  assign w_sample = (r_vote[1] & r_vote[0]) | (r_vote[1] & w_rxs) | (r_vote[0] & w_rxs);
`else
  assign w_sample = w_rxs;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_sc_clr    = 1'b0;
    w_bit_take  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_sc_clr    = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_tick && (r_sc == 4'(MID_SAMPLE))) begin
          w_sc_clr    = 1'b1;
          w_state_nxt = w_sample ? IDLE : DATA;
        end
      end
      DATA: begin
        // sc wraps 15 -> 0 on its own, giving 16-tick spacing per bit
        if (w_tick && (r_sc == 4'(OVERSAMPLE - 1))) begin
          w_bit_take = 1'b1;
          if (r_bi == 3'd7) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_tick && (r_sc == 4'(OVERSAMPLE - 1))) begin
          w_load      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sample counter, bit index, shift register and holding register
  always_ff @(posedge clk) begin
    if (!RST) begin
      r_sc          <= '0;
      r_bi          <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_rx_full     <= 1'b0;
      r_framing_err <= 1'b0;
      r_overrun     <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      if (w_sc_clr) begin
        r_sc <= '0;
        r_bi <= '0;
      end else begin
        if (w_tick) begin
          r_sc <= r_sc + 4'd1;
        end
        if (w_bit_take) begin
          r_bi <= r_bi + 3'd1;
        end
      end

      if (w_bit_take) begin
        r_shift <= {w_sample, r_shift[7:1]};
      end

      if (w_load) begin
        if (!r_rx_full || rd_strobe) begin
          r_data        <= r_shift;
          r_rx_full     <= 1'b1;
          r_framing_err <= ~w_sample;
          r_overrun     <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (rd_strobe) begin
        r_rx_full     <= 1'b0;
        r_framing_err <= 1'b0;
        r_overrun     <= 1'b0;
      end

      r_irq <= r_rx_full & irq_en;
    end
  end

  assign data_out    = r_data;
  assign rx_full     = r_rx_full;
  assign framing_err = r_framing_err;
  assign overrun     = r_overrun;
  assign irq         = r_irq;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_acia_rx.sv
// -----------------------------------------------------------------------------
// tb_acia_rx
// Directed bench for acia_rx. The divisor is scaled down (8 instead of 163)
// so a whole frame takes 1280 cycles; all timing relations are expressed in
// ticks and carry over unchanged. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_acia_rx;
  import acia_pkg::*;

  localparam int DIV  = 8;
  localparam int SYNC = 2;
  localparam int BIT  = DIV * 16;
  localparam int LAT  = 152 * DIV + SYNC + 1;

  // clock / reset block
  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic rx        = 1'b1;
  logic rd_strobe = 1'b0;
  logic irq_en    = 1'b0;

  logic [7:0] data_out;
  logic       rx_full;
  logic       framing_err;
  logic       overrun;
  logic       irq;
  rx_state_t  dbg_state;

  always #10 clk = ~clk;

  acia_rx #(
    .DIVISOR     (DIV),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .RST         (rst_n),
    .rx          (rx),
    .rd_strobe   (rd_strobe),
    .irq_en      (irq_en),
    .data_out    (data_out),
    .rx_full     (rx_full),
    .framing_err (framing_err),
    .overrun     (overrun),
    .irq         (irq),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_data(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got=%0h expected=<empty queue>", tag, data_out);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, data_out}, {24'd0, e});
    end
  endtask

  // driver tasks (called on a falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT);
    end
    rx = stop;
    idle(BIT);
    rx = 1'b1;
  endtask

  task automatic rd_pulse;
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // reset values
    @(negedge clk);
    idle(5);
    check("rst_data", {24'd0, data_out}, 32'h00);
    check("rst_full", {31'd0, rx_full}, 32'd0);
    check("rst_fe", {31'd0, framing_err}, 32'd0);
    check("rst_ov", {31'd0, overrun}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    idle(10);

    // 0x60: exact load latency and irq one cycle behind rx_full
    irq_en = 1'b1;
    exp_q.push_back(8'h60);
    fork
      send_frame(8'h60, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        check("lat_before", {31'd0, rx_full}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_full", {31'd0, rx_full}, 32'd1);
        check_data("lat_data");
        check("lat_fe", {31'd0, framing_err}, 32'd0);
        check("irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_set", {31'd0, irq}, 32'd1);
      end
    join
    idle(100);
    rd_pulse();
    check("rd1_full", {31'd0, rx_full}, 32'd0);
    check("rd1_irq", {31'd0, irq}, 32'd0);

    // 0xA5 with stop bit low, interrupts disabled
    irq_en = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0);
    idle(200);
    check_data("fe_data");
    check("fe_flag", {31'd0, framing_err}, 32'd1);
    check("fe_full", {31'd0, rx_full}, 32'd1);
    check("fe_irq_off", {31'd0, irq}, 32'd0);
    check("fe_state", 32'(dbg_state), 32'(IDLE));
    rd_pulse();
    check("fe_clr", {31'd0, framing_err}, 32'd0);
    check("fe_clr_full", {31'd0, rx_full}, 32'd0);

    // short low glitch, then a good 0x3C frame
    irq_en = 1'b1;
    rx = 1'b0;
    idle(25);
    rx = 1'b1;
    idle(200);
    check("gl_full", {31'd0, rx_full}, 32'd0);
    check("gl_state", 32'(dbg_state), 32'(IDLE));
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(100);
    check_data("gl_data");
    check("gl_full2", {31'd0, rx_full}, 32'd1);
    check("gl_fe", {31'd0, framing_err}, 32'd0);
    rd_pulse();

    // overrun: 0x11 then 0x22 without a read
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(50);
    send_frame(8'h22, 1'b1);
    idle(100);
    check_data("ov_data");
    check("ov_flag", {31'd0, overrun}, 32'd1);
    check("ov_full", {31'd0, rx_full}, 32'd1);
    check("ov_fe", {31'd0, framing_err}, 32'd0);
    rd_pulse();
    check("ov_clr_full", {31'd0, rx_full}, 32'd0);
    check("ov_clr_fe", {31'd0, framing_err}, 32'd0);
    check("ov_clr_ov", {31'd0, overrun}, 32'd0);

    // read strobe on the exact load cycle of 0x22 while 0x11 is held
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(50);
    check_data("sim_held");
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
      end
    join
    idle(100);
    check_data("sim_data");
    check("sim_full", {31'd0, rx_full}, 32'd1);
    check("sim_ov", {31'd0, overrun}, 32'd0);

    // reset during data bit 3, held until the line is idle again
    fork
      send_frame(8'h5A, 1'b1);
      begin
        idle(4 * BIT + 48);
        rst_n = 1'b0;
        idle(2);
        check("mr_data", {24'd0, data_out}, 32'h00);
        check("mr_full", {31'd0, rx_full}, 32'd0);
        check("mr_ov", {31'd0, overrun}, 32'd0);
        check("mr_fe", {31'd0, framing_err}, 32'd0);
        check("mr_irq", {31'd0, irq}, 32'd0);
        check("mr_state", 32'(dbg_state), 32'(IDLE));
      end
    join
    rst_n = 1'b1;
    idle(100);
    check("mr_no_load", {31'd0, rx_full}, 32'd0);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    idle(100);
    check_data("mr_next_data");
    check("mr_next_full", {31'd0, rx_full}, 32'd1);
    check("mr_next_fe", {31'd0, framing_err}, 32'd0);
    check("mr_next_ov", {31'd0, overrun}, 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
